// File: rtl/alu8_pkg.sv
// alu8_pkg: shared types for the 8-bit ALU transaction controller.
//   alu_op_e     opcode encoding forwarded to the ALU
//   txn_state_e  controller FSM states
//   alu_cmd_t    command record {a, b, op, tag}
//   alu_rsp_t    response record {result, carry, zero, tag}
//   alu8_ref()   reference ALU, used by the optional self-check (ALU8_SELFCHECK_EN)
package alu8_pkg;

  localparam int ALU_TAG_W = 4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } txn_state_e;

  typedef struct packed {
    logic [7:0]           a;
    logic [7:0]           b;
    alu_op_e              op;
    logic [ALU_TAG_W-1:0] tag;
  } alu_cmd_t;

  typedef struct packed {
    logic [7:0]           result;
    logic                 carry;
    logic                 zero;
    logic [ALU_TAG_W-1:0] tag;
  } alu_rsp_t;

  // Returns {carry, zero, result[7:0]}. Sub carry is the 9-bit borrow out,
  // slt is unsigned, shifts are logical by one.
  function automatic logic [9:0] alu8_ref(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input alu_op_e    op);
    logic [8:0] r;
    r = '0;
    case (op)
      ALU_ADD: r = {1'b0, a} + {1'b0, b};
      ALU_SUB: r = {1'b0, a} - {1'b0, b};
      ALU_AND: r = {1'b0, a & b};
      ALU_OR:  r = {1'b0, a | b};
      ALU_XOR: r = {1'b0, a ^ b};
      ALU_SLT: r = {8'h00, (a < b)};
      ALU_SHL: r = {1'b0, a[6:0], 1'b0};
      ALU_SHR: r = {2'b00, a[7:1]};
      default: r = '0;
    endcase
    return {r[8], (r[7:0] == 8'h00), r[7:0]};
  endfunction

endpackage

// File: rtl/alu8_cmd_fifo.sv
// alu8_cmd_fifo: synchronous FIFO of command records.
//   clk, rst_n       clock, synchronous active-low reset (empties the FIFO)
//   push, din        write when push && !full
//   pop, dout        read when pop && !empty; dout shows the head (first-word fall-through)
//   full, empty      status
//   count            occupancy 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap naturally.
module alu8_cmd_fifo
  import alu8_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_cmd_t,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/alu8_txn_ctrl.sv
// alu8_txn_ctrl: initiator side of the 8-bit ALU operand/result interface.
// Queues tagged commands, drives them one at a time onto a combinational ALU,
// captures result/carry/zero and returns a tagged response.
//   clk, rst_n                       clock, synchronous active-low reset
//   cmd_valid/ready, cmd_a/b/op/tag  command channel (ready = FIFO not full)
//   alu_a/b/op                       registered operands to the ALU
//   alu_result/carry/zero            ALU outputs, sampled only in DRIVE
//   rsp_valid/ready, rsp_*           response channel, held while stalled
//   rsp_mismatch                     only with ALU8_SELFCHECK_EN: ALU disagreed
//                                    with the internal reference model
//   count                            FIFO occupancy
//   busy                             FSM not IDLE or FIFO not empty
// Optional macro: ALU8_SELFCHECK_EN.
module alu8_txn_ctrl
  import alu8_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  TAG_W = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [7:0]       alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
`ifdef ALU8_SELFCHECK_EN
  output logic             rsp_mismatch,
`endif
  output logic [CW-1:0]    count,
  output logic             busy
);

  // Local record so the tag follows TAG_W rather than the package default.
  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    alu_op_e          op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  txn_state_e       state_q, state_d;
  cmd_t             din, head;
  logic             full, empty;
  logic             push, pop, cap, hs;
  logic [TAG_W-1:0] tag_q;

  assign din       = '{a: cmd_a, b: cmd_b, op: alu_op_e'(cmd_op), tag: cmd_tag};
  // Gated by rst_n so nothing is accepted while reset is held.
  assign cmd_ready = rst_n && !full;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE) || !empty;

  alu8_cmd_fifo #(.DEPTH(DEPTH), .T(cmd_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = DRIVE;
      DRIVE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = empty ? IDLE : DRIVE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    pop = 1'b0;
    cap = 1'b0;
    hs  = 1'b0;
    case (state_q)
      IDLE:  pop = !empty;
      DRIVE: cap = 1'b1;
      RESP: begin
        hs  = rsp_ready;
        pop = rsp_ready && !empty;
      end
      default: ;
    endcase
  end

  // Operand / response datapath. rsp_valid is high exactly while in RESP;
  // any handshake clears it, including the back-to-back path to DRIVE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      tag_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      if (pop) begin
        alu_a  <= head.a;
        alu_b  <= head.b;
        alu_op <= head.op;
        tag_q  <= head.tag;
      end
      if (cap) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_zero   <= alu_zero;
        rsp_tag    <= tag_q;
      end else if (hs) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

`ifdef ALU8_SELFCHECK_EN
  logic [9:0] gold;
  assign gold = alu8_ref(alu_a, alu_b, alu_op_e'(alu_op));

  always_ff @(posedge clk) begin
    if (!rst_n)   rsp_mismatch <= 1'b0;
    else if (cap) rsp_mismatch <= (gold != {alu_carry, alu_zero, alu_result});
  end
`endif

endmodule

// File: tb/tb_alu8_txn_ctrl.sv
// tb_alu8_txn_ctrl: directed bench for alu8_txn_ctrl with a behavioural alu8
// attached to the alu_* port. Expected values are hand-computed constants.
module tb_alu8_txn_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_tag = '0;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_carry, alu_zero;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_result;
  logic       rsp_carry, rsp_zero;
  logic [3:0] rsp_tag;
  logic [2:0] count;
  logic       busy;
`ifdef ALU8_SELFCHECK_EN
  logic       rsp_mismatch;
`endif
  logic       force_res = 1'b0;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu8_txn_ctrl #(.DEPTH(4), .TAG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_tag    (rsp_tag),
`ifdef ALU8_SELFCHECK_EN
    .rsp_mismatch (rsp_mismatch),
`endif
    .count      (count),
    .busy       (busy)
  );

  // Behavioural combinational alu8; force_res corrupts only the result.
  always_comb begin
    logic [8:0] r;
    r = 9'h000;
    case (alu_op)
      3'd0: r = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: r = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: r = {1'b0, alu_a & alu_b};
      3'd3: r = {1'b0, alu_a | alu_b};
      3'd4: r = {1'b0, alu_a ^ alu_b};
      3'd5: r = {8'h00, alu_a < alu_b};
      3'd6: r = {1'b0, alu_a[6:0], 1'b0};
      default: r = {2'b00, alu_a[7:1]};
    endcase
    alu_carry  = r[8];
    alu_zero   = (r[7:0] == 8'h00);
    alu_result = force_res ? 8'h00 : r[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic [3:0] tag);
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    while (!cmd_ready && n < 64) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) chk("send_timeout", cmd_ready, 1);
    else begin @(posedge clk); #1; end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 32) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [3:0] tag, input logic [7:0] er,
                         input logic ec, input logic ez);
    send(a, b, op, tag);
    wait_rsp();
    chk("one_result", rsp_result, er);
    chk("one_carry",  rsp_carry,  ec);
    chk("one_zero",   rsp_zero,   ez);
    chk("one_tag",    rsp_tag,    tag);
    @(posedge clk); #1;
  endtask

  logic [7:0] exp8 [8] = '{8'h83, 8'h7F, 8'h00, 8'h83, 8'h83, 8'h00, 8'h02, 8'h40};

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_count",     count, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_alu",       {alu_a, alu_b, 5'd0, alu_op}, 0);
    chk("rst_rsp",       {rsp_result, 6'd0, rsp_carry, rsp_zero, 4'd0, rsp_tag}, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", cmd_ready, 1);
    @(posedge clk); #1;

    // Single add, latency and DRIVE-phase operands
    rsp_ready = 1'b1;
    send(8'hF0, 8'h20, 3'd0, 4'd3);
    chk("t1_count_e0", count, 1);
    chk("t1_valid_e0", rsp_valid, 0);
    @(posedge clk); #1;
    chk("t1_alu_a", alu_a, 8'hF0);
    chk("t1_alu_b", alu_b, 8'h20);
    chk("t1_alu_op", alu_op, 0);
    chk("t1_valid_e1", rsp_valid, 0);
    chk("t1_busy", busy, 1);
    @(posedge clk); #1;
    chk("t1_valid_e2", rsp_valid, 1);
    chk("t1_result", rsp_result, 8'h10);
    chk("t1_carry", rsp_carry, 1);
    chk("t1_zero", rsp_zero, 0);
    chk("t1_tag", rsp_tag, 3);
    @(posedge clk); #1;
    chk("t1_valid_done", rsp_valid, 0);
    chk("t1_idle", busy, 0);

    // Subtracts
    run_one(8'h05, 8'h05, 3'd1, 4'd1, 8'h00, 1'b0, 1'b1);
    run_one(8'h03, 8'h05, 3'd1, 4'd2, 8'hFE, 1'b1, 1'b0);

    // Backpressure: one in flight + 4 queued fills DEPTH=4
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h10, 8'(i), 3'd0, 4'(i));
    chk("bp_ready", cmd_ready, 0);
    chk("bp_count", count, 4);
    cmd_a = 8'hAA; cmd_b = 8'h01; cmd_op = 3'd0; cmd_tag = 4'd9; cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stall_count", count, 4);
    chk("bp_stall_valid", rsp_valid, 1);
    chk("bp_stall_tag", rsp_tag, 0);
    chk("bp_stall_res", rsp_result, 8'h10);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp();
      chk("bp_tag", rsp_tag, i);
      chk("bp_res", rsp_result, 8'h10 + 8'(i));
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("bp_no_extra", rsp_valid, 0);
    chk("bp_drained", count, 0);
    chk("bp_busy", busy, 0);

    // Streaming all 8 opcodes
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'h81, 8'h02, 3'(i), 4'(i));
      end
      begin
        int last = 0;
        for (int i = 0; i < 8; i++) begin
          wait_rsp();
          chk("st_res", rsp_result, exp8[i]);
          chk("st_tag", rsp_tag, i);
          if (i > 0) chk("st_gap", cyc - last, 2);
          last = cyc;
          @(posedge clk); #1;
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("st_idle", busy, 0);

    // Reset while in DRIVE with 3 queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h20 + 8'(i), 8'h01, 3'd0, 4'(i));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("mr_drive_valid", rsp_valid, 0);
    chk("mr_drive_count", count, 3);
    chk("mr_drive_alu_a", alu_a, 8'h21);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mr_valid", rsp_valid, 0);
    chk("mr_count", count, 0);
    chk("mr_busy", busy, 0);
    chk("mr_alu", {alu_a, alu_b, 5'd0, alu_op}, 0);
    chk("mr_ready", cmd_ready, 0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (rsp_valid) seen++;
      end
      chk("mr_stale", seen, 0);
    end

`ifdef ALU8_SELFCHECK_EN
    force_res = 1'b1;
    send(8'h01, 8'h01, 3'd0, 4'd7);
    wait_rsp();
    chk("sc_forced_res", rsp_result, 8'h00);
    chk("sc_forced_mm", rsp_mismatch, 1);
    @(posedge clk); #1;
    force_res = 1'b0;
    send(8'h01, 8'h01, 3'd0, 4'd8);
    wait_rsp();
    chk("sc_clean_res", rsp_result, 8'h02);
    chk("sc_clean_mm", rsp_mismatch, 0);
    @(posedge clk); #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu8_txn_ctrl.md
Name: alu8_txn_ctrl

Overview:
Initiator side of the 8-bit ALU operand/result interface. Accepts tagged ALU commands over a valid/ready channel and buffers them in a small FIFO. Drives them one at a time onto the combinational ALU's a/b/op inputs, captures result/carry/zero, and returns a tagged response over a second valid/ready channel. Sits between a command source (test sequencer or bridge) and the alu8 instance.

Parameters:
DEPTH, 4, command FIFO depth; power of 2, at least 2
TAG_W, 4, width of the command/response tag

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO can accept
cmd_a  in  8  operand a
cmd_b  in  8  operand b
cmd_op  in  3  opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 shl, 7 shr
cmd_tag  in  TAG_W  transaction tag, returned unchanged
alu_a  out  8  registered operand to ALU
alu_b  out  8  registered operand to ALU
alu_op  out  3  registered opcode to ALU
alu_result  in  8  ALU result
alu_carry  in  1  ALU carry
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_result  out  8  captured result
rsp_carry  out  1  captured carry
rsp_zero  out  1  captured zero
rsp_tag  out  TAG_W  tag of the command
count  out  $clog2(DEPTH+1)  FIFO occupancy
busy  out  1  FSM not IDLE or count nonzero

Behaviour:
- Reset (rst_n low at a clk edge): FIFO empty, count=0, state IDLE, alu_a/alu_b/alu_op=0, rsp_valid=0, rsp_result/carry/zero/tag=0. While rst_n is low, cmd_ready=0 and no push occurs. A reset mid-transaction discards the in-flight command and all queued commands.
- cmd_ready = !full (registered-state only). It never depends combinationally on rsp_ready or cmd_valid. A push occurs when cmd_valid && cmd_ready.
- Full: cmd_ready=0 and cmd_* are ignored. There is no pass-through when full, even if a pop happens in the same cycle.
- Push and pop in the same cycle on a non-full FIFO: count is unchanged and order is preserved. Read/write pointers wrap modulo DEPTH.
- FSM, three states:
  - IDLE: if count!=0, pop head into alu_a/b/op and the tag register, then go to DRIVE.
  - DRIVE: alu_* held stable for exactly one cycle. At end of cycle, register alu_result/carry/zero into rsp_*, set rsp_valid=1, go to RESP.
  - RESP: rsp_* held stable while rsp_valid && !rsp_ready. On handshake, if count!=0, pop next and go to DRIVE (back-to-back); else go to IDLE and clear rsp_valid.
- Latency: command accepted at edge E0 into an empty, idle block gives rsp_valid high after edge E2. Sustained throughput is one command per 2 cycles with rsp_ready held high.
- alu_* retain the last driven values in IDLE/RESP. The ALU outputs are sampled only in DRIVE.
- All 8 opcodes are forwarded unmodified; no illegal-op handling. Tag is opaque and may repeat.

Optional Feature:
- Macro ALU8_SELFCHECK_EN.
- When defined:
  - Adds output rsp_mismatch (1 bit, reset 0), registered alongside rsp_*.
  - An internal golden model evaluates the driven a/b/op: 9-bit add/sub carry; carry=0 for ops 2-7; slt unsigned; shl/shr logical by 1; zero = (result==0).
  - rsp_mismatch=1 if any of result/carry/zero differs from the captured ALU outputs.
- When undefined: port and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package alu8_pkg:
  - alu_op_e enum (ALU_ADD=0 … ALU_SHR=7)
  - txn_state_e (IDLE, DRIVE, RESP)
  - alu_cmd_t struct {a, b, op, tag}
  - alu_rsp_t struct {result, carry, zero, tag}
- Sub-module alu8_cmd_fifo: parameterised sync FIFO of alu_cmd_t with push/pop/full/empty/count. The FSM lives in alu8_txn_ctrl.

Test Plan:
- Reset, then a single add a=0xF0 b=0x20 tag=3 with rsp_ready=1 -> rsp_valid 2 cycles after accept; alu_a=0xF0 during DRIVE; rsp_result=0x10, carry=1, zero=0, tag=3.
- Sub a=0x05 b=0x05 -> result 0x00, carry=0, zero=1. Sub a=0x03 b=0x05 -> result 0xFE, carry=1.
- Hold rsp_ready=0 and push 5 commands with DEPTH=4 -> cmd_ready drops after the 4th queued command (one is in flight), count=4. The 6th offer stalls; rsp_* stay stable. Release rsp_ready -> responses return in tag order 0..4.
- Stream 8 commands (ops 0-7, a=0x81 b=0x02) with rsp_ready=1 -> one response every 2 cycles. Results: 0x83, 0x7F, 0x00, 0x83, 0x83, 0x00, 0x02, 0x40.
- Drop rst_n while in DRIVE with 3 queued -> next cycle: rsp_valid=0, count=0, busy=0, alu_*=0. No stale response appears afterward.
- With ALU8_SELFCHECK_EN, force alu_result to 0x00 for add 0x01+0x01 -> rsp_mismatch=1. Unforced -> 0.
